// File: rtl/call_arbiter_if.sv
// Seat-call arbiter bus: seat buttons and attendant handshake in, call lights and grant status out.
// master = seat panel / attendant side, slave = arbiter.
interface call_arbiter_if #(
  parameter int unsigned NSEAT = 4
);
  localparam int unsigned IdW = $clog2(NSEAT);

  logic [NSEAT-1:0] call;
  logic [NSEAT-1:0] cancel;
  logic             ack;
  logic             done;
  logic [NSEAT-1:0] pending;
  logic             grant_valid;
  logic [IdW-1:0]   grant_id;
  logic             busy;
  logic [7:0]       served_count;

  modport master (
    output call, cancel, ack, done,
    input  pending, grant_valid, grant_id, busy, served_count
  );

  modport slave (
    input  call, cancel, ack, done,
    output pending, grant_valid, grant_id, busy, served_count
  );
endinterface

// File: rtl/call_arbiter.sv
// Round-robin seat call arbiter: latches seat calls and offers them one at a time to the attendant.
// Optional offer timeout is built only when CALL_TIMEOUT_EN is defined.
module call_arbiter #(
  parameter int unsigned NSEAT   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  call_arbiter_if.slave bus
);

  localparam int unsigned IdW = $clog2(NSEAT);

  if (NSEAT < 2 || NSEAT > 16 || TIMEOUT < 1) begin : g_param_check
    $error("call_arbiter: NSEAT must be 2..16 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {StIdle, StOffer, StServe} state_e;

  state_e           state_q, state_d;
  logic [NSEAT-1:0] pending_q, pending_d, clr;
  logic [IdW-1:0]   grant_id_q, grant_id_d;
  logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]   pick, gid_next;
  logic [IdW:0]     idx;
  logic             found;
  logic [7:0]       served_q, served_d;

`ifdef CALL_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);
  logic [TimerW-1:0] timer_q, timer_d;
`endif

  // First pending seat at or above rr_ptr, wrapping past the top seat.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NSEAT; i++) begin
      idx = {1'b0, rr_ptr_q} + (IdW + 1)'(i);
      if (idx >= (IdW + 1)'(NSEAT)) begin
        idx = idx - (IdW + 1)'(NSEAT);
      end
      if (!found && pending_q[idx[IdW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IdW-1:0];
      end
    end
  end

  assign gid_next = (grant_id_q == IdW'(NSEAT - 1)) ? '0 : grant_id_q + 1'b1;

  // A fresh call always wins over cancel and over the ack clear.
  always_comb begin
    clr = '0;
    if (state_q == StOffer && bus.ack) begin
      clr[grant_id_q] = 1'b1;
    end
    pending_d = bus.call | (pending_q & ~bus.cancel & ~clr);
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    served_d   = served_q;
    case (state_q)
      StIdle: begin
        grant_id_d = '0;
        if (found) begin
          state_d    = StOffer;
          grant_id_d = pick;
        end
      end
      StOffer: begin
        if (bus.ack) begin
          state_d  = StServe;
          rr_ptr_d = gid_next;
        end else if (!pending_d[grant_id_q]) begin
          state_d    = StIdle;
          grant_id_d = '0;
`ifdef CALL_TIMEOUT_EN
        end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
          // Give up on this seat for now but keep its light on; others get a turn first.
          state_d    = StIdle;
          grant_id_d = '0;
          rr_ptr_d   = gid_next;
`endif
        end
      end
      StServe: begin
        if (bus.done) begin
          state_d    = StIdle;
          grant_id_d = '0;
          if (served_q != 8'hFF) begin
            served_d = served_q + 8'd1;
          end
        end
      end
      default: begin
        state_d    = StIdle;
        grant_id_d = '0;
      end
    endcase
  end

`ifdef CALL_TIMEOUT_EN
  always_comb begin
    timer_d = '0;
    if (state_q == StOffer && state_d == StOffer) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      served_q   <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      served_q   <= served_d;
    end
  end

  assign bus.pending      = pending_q;
  assign bus.grant_valid  = (state_q == StOffer);
  assign bus.busy         = (state_q == StServe);
  assign bus.grant_id     = grant_id_q;
  assign bus.served_count = served_q;

endmodule

// File: tb/tb_call_arbiter.sv
// Self-checking bench for call_arbiter: expected grant order kept in a scoreboard queue.
module tb_call_arbiter;

  localparam int unsigned NSEAT   = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned IdW     = $clog2(NSEAT);

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   served_exp = 0;
  int   exp_q[$];

  call_arbiter_if #(.NSEAT(NSEAT)) bus ();

  call_arbiter #(.NSEAT(NSEAT), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.call   = '0;
    bus.cancel = '0;
    bus.ack    = 1'b0;
    bus.done   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
    served_exp = 0;
    exp_q.delete();
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.grant_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.call = '1;
    bus.cancel = '0;
    bus.ack = 1'b1;
    bus.done = 1'b1;
    tick();
    n_cmp++;
    if ({bus.pending, bus.grant_valid, bus.busy, bus.grant_id, bus.served_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got pend=%b gv=%b busy=%b gid=%0d cnt=%0d want all 0",
               bus.pending, bus.grant_valid, bus.busy, bus.grant_id, bus.served_count);
    end
    reset = 1'b0;
    idle_inputs();
    tick();
    n_cmp++;
    if (bus.pending !== 4'b0000 || bus.grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got pend=%b gv=%b want 0000 0", bus.pending, bus.grant_valid);
    end
  endtask

  task automatic test_single_call();
    int e;
    bus.call = 4'b0100;
    exp_q.push_back(2);
    tick();
    bus.call = '0;
    n_cmp++;
    if (bus.pending !== 4'b0100 || bus.grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pending: got pend=%b gv=%b want 0100 0", bus.pending, bus.grant_valid);
    end
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if (bus.grant_valid !== 1'b1 || bus.grant_id !== IdW'(e)) begin
      n_fail++;
      $display("FAIL single_offer: got gv=%b gid=%0d want 1 %0d", bus.grant_valid, bus.grant_id, e);
    end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    n_cmp++;
    if (bus.pending !== 4'b0000 || bus.busy !== 1'b1 || bus.grant_valid !== 1'b0 ||
        bus.grant_id !== IdW'(2)) begin
      n_fail++;
      $display("FAIL single_ack: got pend=%b busy=%b gv=%b gid=%0d want 0000 1 0 2",
               bus.pending, bus.busy, bus.grant_valid, bus.grant_id);
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    served_exp++;
    n_cmp++;
    if (bus.served_count !== 8'(served_exp) || bus.busy !== 1'b0 || bus.grant_id !== '0) begin
      n_fail++;
      $display("FAIL single_done: got cnt=%0d busy=%b gid=%0d want %0d 0 0",
               bus.served_count, bus.busy, bus.grant_id, served_exp);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int e;
    do_reset();
    bus.call = 4'b1011;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(3);
    exp_q.push_back(0);
    for (int k = 0; k < 4; k++) begin
      wait_grant(ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || bus.grant_id !== IdW'(e)) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got gv=%b gid=%0d want 1 %0d", k, ok, bus.grant_id, e);
      end
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      served_exp++;
    end
    n_cmp++;
    if (bus.pending !== 4'b1011 || bus.served_count !== 8'(served_exp)) begin
      n_fail++;
      $display("FAIL rr_final: got pend=%b cnt=%0d want 1011 %0d",
               bus.pending, bus.served_count, served_exp);
    end
    do_reset();
  endtask

  task automatic test_cancel_offer();
    bit ok;
    int e;
    bus.call = 4'b0010;
    exp_q.push_back(1);
    tick();
    bus.call = '0;
    wait_grant(ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || bus.grant_id !== IdW'(e)) begin
      n_fail++;
      $display("FAIL cancel_offer_gid: got gv=%b gid=%0d want 1 %0d", ok, bus.grant_id, e);
    end
    bus.cancel = 4'b0010;
    tick();
    bus.cancel = '0;
    n_cmp++;
    if (bus.grant_valid !== 1'b0 || bus.busy !== 1'b0 || bus.grant_id !== '0 ||
        bus.pending !== 4'b0000 || bus.served_count !== 8'(served_exp)) begin
      n_fail++;
      $display("FAIL cancel_idle: got gv=%b busy=%b gid=%0d pend=%b cnt=%0d want 0 0 0 0000 %0d",
               bus.grant_valid, bus.busy, bus.grant_id, bus.pending, bus.served_count,
               served_exp);
    end
    tick();
    n_cmp++;
    if (bus.grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_no_reoffer: got gv=%b want 0", bus.grant_valid);
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    int e;
    bus.call = 4'b0001;
    bus.cancel = 4'b0001;
    exp_q.push_back(0);
    tick();
    idle_inputs();
    n_cmp++;
    if (bus.pending[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL call_beats_cancel: got pend=%b want xxx1", bus.pending);
    end
    wait_grant(ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || bus.grant_id !== IdW'(e)) begin
      n_fail++;
      $display("FAIL simul_offer: got gv=%b gid=%0d want 1 %0d", ok, bus.grant_id, e);
    end
    bus.ack = 1'b1;
    bus.done = 1'b1;
    bus.cancel = 4'b0001;
    tick();
    idle_inputs();
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.pending !== 4'b0000 || bus.served_count !== 8'(served_exp)) begin
      n_fail++;
      $display("FAIL ack_beats_cancel_done: got busy=%b pend=%b cnt=%0d want 1 0000 %0d",
               bus.busy, bus.pending, bus.served_count, served_exp);
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    served_exp++;
    n_cmp++;
    if (bus.served_count !== 8'(served_exp) || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_done: got cnt=%0d busy=%b want %0d 0",
               bus.served_count, bus.busy, served_exp);
    end
  endtask

  task automatic test_ignored();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.grant_valid !== 1'b0 || bus.served_count !== 8'(served_exp)) begin
      n_fail++;
      $display("FAIL idle_ack_done: got busy=%b gv=%b cnt=%0d want 0 0 %0d",
               bus.busy, bus.grant_valid, bus.served_count, served_exp);
    end
  endtask

  task automatic test_serve_new_call();
    bit ok;
    int e;
    bus.call = 4'b0100;
    exp_q.push_back(2);
    tick();
    bus.call = '0;
    wait_grant(ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || bus.grant_id !== IdW'(e)) begin
      n_fail++;
      $display("FAIL serve_offer: got gv=%b gid=%0d want 1 %0d", ok, bus.grant_id, e);
    end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    bus.call = 4'b0101;
    tick();
    bus.call = '0;
    tick();
    n_cmp++;
    if (bus.pending !== 4'b0101 || bus.grant_valid !== 1'b0 || bus.busy !== 1'b1 ||
        bus.grant_id !== IdW'(2)) begin
      n_fail++;
      $display("FAIL serve_hold: got pend=%b gv=%b busy=%b gid=%0d want 0101 0 1 2",
               bus.pending, bus.grant_valid, bus.busy, bus.grant_id);
    end
    exp_q.push_back(0);
    exp_q.push_back(2);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    served_exp++;
    for (int k = 0; k < 2; k++) begin
      wait_grant(ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || bus.grant_id !== IdW'(e)) begin
        n_fail++;
        $display("FAIL serve_next[%0d]: got gv=%b gid=%0d want 1 %0d", k, ok, bus.grant_id, e);
      end
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      served_exp++;
    end
    n_cmp++;
    if (bus.served_count !== 8'(served_exp)) begin
      n_fail++;
      $display("FAIL serve_count: got %0d want %0d", bus.served_count, served_exp);
    end
  endtask

  task automatic test_reset_abort();
    bit ok;
    int e;
    bus.call = 4'b0010;
    tick();
    bus.call = '0;
    wait_grant(ok);
    reset = 1'b1;
    bus.ack = 1'b1;
    tick();
    reset = 1'b0;
    bus.ack = 1'b0;
    served_exp = 0;
    tick();
    tick();
    tick();
    n_cmp++;
    if (!ok || bus.grant_valid !== 1'b0 || bus.pending !== 4'b0000 ||
        bus.served_count !== 8'(served_exp)) begin
      n_fail++;
      $display("FAIL abort_offer: got offered=%b gv=%b pend=%b cnt=%0d want 1 0 0000 %0d",
               ok, bus.grant_valid, bus.pending, bus.served_count, served_exp);
    end
    bus.call = 4'b1000;
    exp_q.push_back(3);
    tick();
    bus.call = '0;
    wait_grant(ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || bus.grant_id !== IdW'(e)) begin
      n_fail++;
      $display("FAIL abort_serve_offer: got gv=%b gid=%0d want 1 %0d", ok, bus.grant_id, e);
    end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    reset = 1'b1;
    bus.done = 1'b1;
    tick();
    reset = 1'b0;
    bus.done = 1'b0;
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.grant_valid !== 1'b0 || bus.served_count !== 8'(served_exp)) begin
      n_fail++;
      $display("FAIL abort_serve: got busy=%b gv=%b cnt=%0d want 0 0 %0d",
               bus.busy, bus.grant_valid, bus.served_count, served_exp);
    end
  endtask

  task automatic test_saturation();
    bit ok;
    int missed;
    do_reset();
    missed = 0;
    for (int n = 0; n < 260; n++) begin
      bus.call = 4'b1000;
      tick();
      bus.call = '0;
      wait_grant(ok);
      if (!ok) missed++;
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      if (served_exp < 255) served_exp++;
      if (n == 253) begin
        n_cmp++;
        if (bus.served_count !== 8'd254) begin
          n_fail++;
          $display("FAIL sat_254: got %0d want 254", bus.served_count);
        end
      end
    end
    n_cmp++;
    if (missed != 0 || bus.served_count !== 8'(served_exp) || served_exp != 255) begin
      n_fail++;
      $display("FAIL saturation: got cnt=%0d missed=%0d want 255 0", bus.served_count, missed);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int e;
    int cnt;
    do_reset();
    bus.call = 4'b0011;
    exp_q.push_back(0);
    tick();
    bus.call = '0;
    wait_grant(ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || bus.grant_id !== IdW'(e)) begin
      n_fail++;
      $display("FAIL to_first_offer: got gv=%b gid=%0d want 1 %0d", ok, bus.grant_id, e);
    end
    cnt = 0;
`ifdef CALL_TIMEOUT_EN
    while (bus.grant_valid === 1'b1 && bus.grant_id === '0 && cnt < 40) begin
      cnt++;
      tick();
    end
    n_cmp++;
    if (cnt != int'(TIMEOUT) || bus.pending !== 4'b0011) begin
      n_fail++;
      $display("FAIL to_expire: got offer_cycles=%0d pend=%b want %0d 0011",
               cnt, bus.pending, TIMEOUT);
    end
    exp_q.push_back(1);
    wait_grant(ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || bus.grant_id !== IdW'(e) || bus.pending !== 4'b0011) begin
      n_fail++;
      $display("FAIL to_next_seat: got gv=%b gid=%0d pend=%b want 1 %0d 0011",
               ok, bus.grant_id, bus.pending, e);
    end
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.grant_valid !== 1'b1 || bus.grant_id !== '0) cnt++;
    end
    n_cmp++;
    if (cnt != 0 || bus.pending !== 4'b0011) begin
      n_fail++;
      $display("FAIL no_timeout_hold: got dropped_cycles=%0d pend=%b want 0 0011",
               cnt, bus.pending);
    end
`endif
    do_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_single_call();
    test_round_robin();
    test_cancel_offer();
    test_simultaneous();
    test_ignored();
    test_serve_new_call();
    test_reset_abort();
    test_saturation();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/call_arbiter.md
CALL_ARBITER -- requirements
Module: call_arbiter

Interface
REQ-001 The block SHALL have parameter NSEAT, default 4, giving the number of seat call channels; legal values are 2..16.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, giving the number of cycles a grant may wait for ack (used only when CALL_TIMEOUT_EN is defined).
REQ-003 The block SHALL have port clk, input, width 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, width 1; reset is synchronous and active-high.
REQ-005 The block SHALL have port call, input, width NSEAT, the per-seat call button, level-sampled.
REQ-006 The block SHALL have port cancel, input, width NSEAT, the per-seat cancel button, level-sampled.
REQ-007 The block SHALL have port ack, input, width 1, meaning the attendant accepts the offered call.
REQ-008 The block SHALL have port done, input, width 1, meaning the attendant has finished servicing the call.
REQ-009 The block SHALL have port pending, output, width NSEAT, the registered per-seat call lights.
REQ-010 The block SHALL have port grant_valid, output, width 1, meaning a call is offered to the attendant.
REQ-011 The block SHALL have port grant_id, output, width clog2(NSEAT), giving the seat being offered or serviced.
REQ-012 The block SHALL have port busy, output, width 1, meaning the attendant is servicing a seat.
REQ-013 The block SHALL have port served_count, output, width 8, counting completed services.

Function
REQ-014 Each pending[i] SHALL update every cycle as call[i] OR (pending[i] AND NOT cancel[i] AND NOT clr[i]), where clr[i] is 1 only in the ack cycle for seat grant_id; call has priority over both cancel and clr.
REQ-015 The FSM SHALL have exactly three states: IDLE, OFFER and SERVE, all registered.
REQ-016 In IDLE with any pending bit set, the block SHALL select the first set bit searching upward from rr_ptr with wrap-around, load grant_id with it, and enter OFFER next cycle; with no bit set it SHALL remain in IDLE.
REQ-017 Latency SHALL be as follows: a call sampled at edge k sets pending after edge k, and grant_valid is high after edge k+1 if the FSM was IDLE.
REQ-018 In OFFER, grant_valid SHALL be 1; ack SHALL move the FSM to SERVE, clear pending[grant_id] per REQ-014, and set rr_ptr to grant_id+1 mod NSEAT.
REQ-019 In OFFER, if pending[grant_id] drops by cancel without ack, the FSM SHALL return to IDLE with rr_ptr unchanged; if ack and cancel coincide, ack SHALL win.
REQ-020 In SERVE, busy SHALL be 1, grant_valid SHALL be 0, and grant_id SHALL be held; done SHALL return the FSM to IDLE and increment served_count, saturating at 255.
REQ-021 ack outside OFFER and done outside SERVE SHALL be ignored; ack and done in the same OFFER cycle SHALL be treated as ack only.
REQ-022 New calls, including from the serviced seat, SHALL set pending during SERVE but SHALL NOT be offered until return to IDLE.
REQ-023 grant_id SHALL be 0 whenever the FSM is IDLE.

Reset
REQ-024 While reset is high at a clock edge, the block SHALL set the state to IDLE, and pending, grant_valid, grant_id, busy, served_count, rr_ptr and the timeout counter to 0; reset SHALL override call, ack and done in that cycle.
REQ-025 Reset asserted in OFFER or SERVE SHALL abort the call with no count increment, and the seat SHALL NOT be re-offered unless called again.

Configuration
REQ-026 When CALL_TIMEOUT_EN is defined, an OFFER lasting TIMEOUT cycles without ack SHALL return the FSM to IDLE, keep pending[grant_id] set, and set rr_ptr to grant_id+1 so that other seats are offered first.
REQ-027 When CALL_TIMEOUT_EN is undefined, OFFER SHALL wait indefinitely and no timeout counter SHALL be synthesized.

Verification
REQ-028 The bench SHALL cover single call: with NSEAT=4, call[2] pulse at cycle 1 -> pending=0100 after cycle 1, grant_valid=1 with grant_id=2 after cycle 2; ack -> pending=0000, busy=1; done -> served_count=1.
REQ-029 The bench SHALL cover round-robin: pending=1011 held by repeated call with rr_ptr=0 -> offer order is seats 0, 1, 3, then 0 again.
REQ-030 The bench SHALL cover cancel during offer: call[1], then cancel[1] while grant_valid=1 -> FSM in IDLE next cycle, served_count unchanged, grant_valid=0.
REQ-031 The bench SHALL cover simultaneous events: call[0] and cancel[0] in the same cycle -> pending[0]=1; ack and cancel on the offered seat in the same cycle -> SERVE.
REQ-032 The bench SHALL cover saturation: 260 complete call/ack/done cycles -> served_count=255.
REQ-033 The bench SHALL cover timeout with CALL_TIMEOUT_EN and TIMEOUT=16: pending=0011 with no ack for 16 OFFER cycles -> seat 1 offered next and pending still 0011; without the macro, seat 0 is held offered for 100 cycles.
